// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the E stage: single-cycle multiply, 32-step restoring divide,
// MTHI/MTLO/MFHI/MFLO, pipeline stall and flush-aware commit.
module hilo_muldiv_ctrl #(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluopE,
  input  logic        validE,
  input  logic        flushE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic        stallE,
  output logic        busy,
  output logic [31:0] hilo_rdata
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  localparam logic [7:0] ALUOP_MULT  = 8'h10;
  localparam logic [7:0] ALUOP_MULTU = 8'h11;
  localparam logic [7:0] ALUOP_DIV   = 8'h12;
  localparam logic [7:0] ALUOP_DIVU  = 8'h13;
  localparam logic [7:0] ALUOP_MTHI  = 8'h14;
  localparam logic [7:0] ALUOP_MTLO  = 8'h15;
  localparam logic [7:0] ALUOP_MFHI  = 8'h16;
  localparam logic [7:0] ALUOP_MFLO  = 8'h17;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    hi, lo, res_hi, res_lo;
  logic [W-1:0]    opa, opb, rem, quo;
  logic [CW-1:0]   count;
  logic            op_div, q_sign, r_sign;

  logic            is_mul, is_div, is_signed, start;
  logic [W-1:0]    a_abs, b_abs;
  logic [W:0]      rem_shift, trial;
  logic            trial_ok, last_iter;
  logic [W-1:0]    rem_nxt, quo_nxt;
  logic [2*W-1:0]  product, prod_s;

  assign is_mul    = (aluopE == ALUOP_MULT) || (aluopE == ALUOP_MULTU);
  assign is_div    = (aluopE == ALUOP_DIV)  || (aluopE == ALUOP_DIVU);
  assign is_signed = (aluopE == ALUOP_MULT) || (aluopE == ALUOP_DIV);
  assign start     = validE && !flushE && (state == IDLE) && (is_mul || is_div);
  assign a_abs     = (is_signed && srcaE[W-1]) ? -srcaE : srcaE;
  assign b_abs     = (is_signed && srcbE[W-1]) ? -srcbE : srcbE;

  // One restoring step: shift, trial-subtract, keep if non-negative
  assign rem_shift = {rem, quo[W-1]};
  assign trial     = rem_shift - {1'b0, opb};
  assign trial_ok  = rem_shift >= {1'b0, opb};
  assign rem_nxt   = trial_ok ? trial[W-1:0] : rem_shift[W-1:0];
  assign quo_nxt   = {quo[W-2:0], trial_ok};
  assign last_iter = (count == CW'(DIV_ITERS - 1));

  assign product = (2*W)'(opa) * (2*W)'(opb);
  assign prod_s  = q_sign ? -product : product;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (is_div && (srcbE != '0)) ? DIV : MUL;
      MUL:  state_nxt = flushE ? IDLE : DONE;
      DIV:  begin
        if (flushE)         state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stallE     = (start || (state == MUL) || (state == DIV)) && !flushE;
    hilo_rdata = '0;
    if (aluopE == ALUOP_MFHI)      hilo_rdata = hi;
    else if (aluopE == ALUOP_MFLO) hilo_rdata = lo;
  end

  // Operand latch, divide iterations, result staging and HI/LO commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      opa    <= '0;
      opb    <= '0;
      rem    <= '0;
      quo    <= '0;
      count  <= '0;
      op_div <= 1'b0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa    <= a_abs;
            opb    <= b_abs;
            op_div <= is_div;
            q_sign <= is_signed && (srcaE[W-1] ^ srcbE[W-1]);
            r_sign <= is_signed && srcaE[W-1];
            count  <= '0;
            rem    <= '0;
            quo    <= a_abs;
          end else if (validE && !flushE) begin
            if (aluopE == ALUOP_MTHI) hi <= srcaE;
            if (aluopE == ALUOP_MTLO) lo <= srcaE;
          end
        end
        MUL: begin
          if (flushE) begin
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
          end else if (op_div) begin
            res_hi <= opa;
            res_lo <= '1;
          end else begin
            {res_hi, res_lo} <= prod_s;
          end
        end
        DIV: begin
          if (flushE) begin
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
          end else begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            count <= count + CW'(1);
            if (last_iter) begin
              res_lo <= q_sign ? -quo_nxt : quo_nxt;
              res_hi <= r_sign ? -rem_nxt : rem_nxt;
            end
          end
        end
        DONE: begin
          if (!flushE) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: MF reads and stall-run lengths are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_hilo_muldiv_ctrl;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MULT  = 8'h10;
  localparam logic [7:0] OP_MULTU = 8'h11;
  localparam logic [7:0] OP_DIV   = 8'h12;
  localparam logic [7:0] OP_DIVU  = 8'h13;
  localparam logic [7:0] OP_MTHI  = 8'h14;
  localparam logic [7:0] OP_MTLO  = 8'h15;
  localparam logic [7:0] OP_MFHI  = 8'h16;
  localparam logic [7:0] OP_MFLO  = 8'h17;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluopE;
  logic        validE, flushE;
  logic [31:0] srcaE, srcbE;
  logic        stallE, busy;
  logic [31:0] hilo_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          stall_q[$];

  int          run_len = 0;
  string       mon_nm;
  logic [31:0] mon_exp;
  int          mon_stall;

  hilo_muldiv_ctrl #(.DIV_ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluopE     (aluopE),
    .validE     (validE),
    .flushE     (flushE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .stallE     (stallE),
    .busy       (busy),
    .hilo_rdata (hilo_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, want);
  endtask

  // Monitor: every valid MF read and every finished stall run pops the scoreboard
  always @(negedge clk) begin
    if (rst && validE && !flushE && (aluopE == OP_MFHI || aluopE == OP_MFLO)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_read: got %h, expected no read", hilo_rdata);
      end else begin
        mon_nm  = name_q.pop_front();
        mon_exp = exp_q.pop_front();
        check(mon_nm, hilo_rdata, mon_exp);
      end
    end
    if (stallE) begin
      run_len++;
    end else if (run_len > 0) begin
      if (stall_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_stall: got %0d cycles, expected none", run_len);
      end else begin
        mon_stall = stall_q.pop_front();
        check("stall_len", 32'(run_len), 32'(mon_stall));
      end
      run_len = 0;
    end
  end

  // Hold one instruction in E until the cycle it is not stalled
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic s;
    logic done;
    done   = 1'b0;
    aluopE = op;
    srcaE  = a;
    srcbE  = b;
    validE = 1'b1;
    flushE = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      s = stallE;
      @(posedge clk);
      #1;
      if (!s) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL issue_timeout: got stall beyond 100 cycles, expected release (op %h)", op);
    end
    validE = 1'b0;
    aluopE = OP_NOP;
  endtask

  task automatic expect_rd(input string nm, input logic [7:0] op, input logic [31:0] val);
    name_q.push_back(nm);
    exp_q.push_back(val);
    issue(op, 32'h0, 32'h0);
  endtask

  initial begin
    rst    = 1'b0;
    aluopE = OP_MFHI;
    validE = 1'b0;
    flushE = 1'b0;
    srcaE  = '0;
    srcbE  = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stallE), 32'd0);
    check("rst_rdata", hilo_rdata, 32'd0);
    @(posedge clk); #1;
    rst    = 1'b1;
    aluopE = OP_NOP;
    @(posedge clk); #1;

    // MULT -3 * 5
    stall_q.push_back(2);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    expect_rd("mult_hi", OP_MFHI, 32'hFFFF_FFFF);
    expect_rd("mult_lo", OP_MFLO, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2
    stall_q.push_back(2);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    expect_rd("multu_hi", OP_MFHI, 32'h0000_0001);
    expect_rd("multu_lo", OP_MFLO, 32'hFFFF_FFFE);

    // DIVU 100 / 7
    stall_q.push_back(33);
    issue(OP_DIVU, 32'd100, 32'd7);
    expect_rd("divu_lo", OP_MFLO, 32'd14);
    expect_rd("divu_hi", OP_MFHI, 32'd2);

    // DIV -7 / 2
    stall_q.push_back(33);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    expect_rd("div_lo", OP_MFLO, 32'hFFFF_FFFD);
    expect_rd("div_hi", OP_MFHI, 32'hFFFF_FFFF);

    // Divide by zero takes the short path
    stall_q.push_back(2);
    issue(OP_DIV, 32'h0000_1234, 32'd0);
    expect_rd("div0_hi", OP_MFHI, 32'h0000_1234);
    expect_rd("div0_lo", OP_MFLO, 32'hFFFF_FFFF);

    // Start coincident with flush: nothing starts
    aluopE = OP_MULT; srcaE = 32'd3; srcbE = 32'd3; validE = 1'b1; flushE = 1'b1;
    @(negedge clk);
    check("flush_start_stall", 32'(stallE), 32'd0);
    @(posedge clk); #1;
    check("flush_start_busy", 32'(busy), 32'd0);
    flushE = 1'b0; validE = 1'b0; aluopE = OP_NOP;
    expect_rd("flush_start_lo", OP_MFLO, 32'hFFFF_FFFF);

    // MT then immediate MF, then a divide flushed in iteration 10
    issue(OP_MTHI, 32'h0000_AAAA, 32'd0);
    expect_rd("mt_mf_hi", OP_MFHI, 32'h0000_AAAA);
    issue(OP_MTLO, 32'h0000_5555, 32'd0);
    stall_q.push_back(10);
    aluopE = OP_DIVU; srcaE = 32'd9; srcbE = 32'd3; validE = 1'b1; flushE = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("div_busy_mid", 32'(busy), 32'd1);
    flushE = 1'b1;
    @(negedge clk);
    check("flush_div_stall", 32'(stallE), 32'd0);
    @(posedge clk); #1;
    flushE = 1'b0; validE = 1'b0; aluopE = OP_NOP;
    check("flush_div_busy", 32'(busy), 32'd0);
    check("flush_div_stall_after", 32'(stallE), 32'd0);
    expect_rd("flush_hi", OP_MFHI, 32'h0000_AAAA);
    expect_rd("flush_lo", OP_MFLO, 32'h0000_5555);

    // Asynchronous reset during divide iteration 5
    stall_q.push_back(5);
    aluopE = OP_DIVU; srcaE = 32'd100; srcbE = 32'd7; validE = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b0; validE = 1'b0; aluopE = OP_NOP;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_stall", 32'(stallE), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    expect_rd("rst_mid_hi", OP_MFHI, 32'd0);
    expect_rd("rst_mid_lo", OP_MFLO, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_left", 32'(exp_q.size() + stall_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Execute-stage controller for multiply, divide and HI/LO moves. It owns the HI/LO register pair and runs a single-cycle multiply and a 32-iteration radix-2 restoring divide. While an operation is in flight it stalls the pipeline, and it commits results to HI/LO only when the instruction is not flushed. It sits beside the ALU in E and consumes the same aluopE produced by the decoder.

## Interface
- DIV_ITERS, 32, divide iteration count; equals the operand width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- aluopE  in  8  E-stage ALU op. Decoded codes: `ALUOP_MULT, `ALUOP_MULTU, `ALUOP_DIV, `ALUOP_DIVU, `ALUOP_MTHI, `ALUOP_MTLO, `ALUOP_MFHI, `ALUOP_MFLO from instrdefines.vh.
- validE  in  1  E-stage instruction is valid.
- flushE  in  1  kill the E-stage instruction this cycle.
- srcaE  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- srcbE  in  32  rt operand: divisor or multiplier.
- stallE  out  1  hold F/D/E; combinational.
- busy  out  1  state is not IDLE; registered.
- hilo_rdata  out  32  HI for MFHI, LO for MFLO, otherwise 0; combinational from the registers.

## Operation
- States: IDLE, MUL, DIV, DONE.
- start = validE & ~flushE & state==IDLE & aluopE is one of the four mul/div codes.
- IDLE handling on start:
  - Latch the absolute value of each operand for signed ops, or the raw value for unsigned ops.
  - Latch the result sign and the remainder sign.
  - MULT/MULTU, or DIV/DIVU with srcbE==0: go to MUL.
  - DIV/DIVU with a nonzero divisor: go to DIV, with count=0, remainder reg=0, quotient reg=dividend.
- MUL (1 cycle):
  - Multiply: 64-bit product, negated if sign set. {res_hi,res_lo} = product.
  - Divide by zero: res_hi = srcaE as latched (unmodified), res_lo = 32'hFFFF_FFFF.
  - Then go to DONE.
- DIV, one iteration per cycle:
  - Shift {rem,quo} left by 1 and trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set the quotient LSB.
  - count increments by 1. When count==DIV_ITERS-1, go to DONE. The last iteration is included.
  - The result is negated into res_lo (quotient) if the quotient sign is set, and into res_hi (remainder) if the remainder sign is set.
  - Signed ops: quotient sign = srca[31]^srcb[31]; remainder sign = srca[31].
- DONE (1 cycle):
  - stallE=0, so the mul/div instruction leaves E.
  - On the clock edge ending DONE: if ~flushE, HI<=res_hi and LO<=res_lo.
  - Go to IDLE. DONE never accepts a start.
- flushE in MUL or DIV: go to IDLE next edge, HI/LO untouched, and clear the count and res regs.
- MTHI/MTLO: in IDLE, if validE & ~flushE, HI (or LO) <= srcaE on the next edge.
- MFHI/MFLO: read registered HI/LO. Back-to-back MT→MF needs no bypass because the write lands before the next E cycle.
- stallE = start | state==MUL | state==DIV, and is gated to 0 when flushE=1.
- Widths: product 64 bits; remainder datapath 33 bits for the trial subtract; count 6 bits.
- Reset (rst=0, async): state=IDLE, HI=0, LO=0, count=0, res regs=0, busy=0.
  - stallE=0 and hilo_rdata=0 because of the reset state.
  - A reset in the middle of an operation abandons it with no commit.

## Timing
- MULT/MULTU, or divide by zero:
  - Start cycle c0: stallE=1.
  - c1 MUL: stallE=1.
  - c2 DONE: stallE=0.
  - HI/LO are visible from c3. Total stall is 2 cycles.
- DIV/DIVU:
  - c0 start: stallE=1.
  - c1..c32 DIV: stallE=1.
  - c33 DONE: stallE=0.
  - HI/LO are visible from c34. Total stall is 33 cycles.
- A mul/div immediately following another: the second one reaches E after DONE, so it starts no earlier than IDLE in c3 (or c34 after a divide).
- An MFHI directly after a MULT therefore reads committed HI.
- flushE together with start: no start, stallE=0.

## Test plan
- MULT srcaE=0xFFFFFFFD (−3), srcbE=5 -> stallE high for 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIVU 100 / 7 -> stallE high for exactly 33 cycles; then LO=14, HI=2.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV with srcbE=0, srcaE=0x1234 -> 2-cycle stall; then HI=0x1234, LO=0xFFFFFFFF.
- HI=0xAAAA and LO=0x5555 preset via MTHI/MTLO; start DIVU 9/3; assert flushE in iteration 10 -> next cycle state=IDLE, stallE=0, HI/LO still 0xAAAA/0x5555.
- Assert rst low during DIV iteration 5 -> busy=0 immediately, HI/LO=0.
